// File: rtl/snn_ctrl_pkg.sv
// Shared types for the SNN layer controllers: sequencer state encoding and
// the fixed-point formats used by the neuron datapath.
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ACCUM  = 3'd2,
    DRAIN  = 3'd3,
    ACTIV  = 3'd4,
    OUTPUT = 3'd5,
    DONE   = 3'd6
  } seq_state_e;

  // Membrane potential / weight format carried by the neuron array.
  localparam int FXP_INT_W  = 8;
  localparam int FXP_FRAC_W = 8;
  localparam int FXP_W      = FXP_INT_W + FXP_FRAC_W;

endpackage

// File: rtl/spike_priority_enc.sv
// Lowest-set-bit encoder: idx is the position of the least significant 1 in
// vec (0 when vec is empty); any flags a non-empty vector.
module spike_priority_enc #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/spike_event_sequencer.sv
// Per-layer event controller: takes one spike vector per timestep, streams its
// set bits as addresses, drains and activates the neuron array, hands results on.
module spike_event_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int EC_SIZE       = 2048,
  parameter int POST_SIZE     = 2048,
  parameter int NEURON_LAT    = 4,
  parameter int NUM_TIMESTEPS = 25,
  parameter int ADDR_W        = $clog2(EC_SIZE),
  parameter int TS_W          = $clog2(NUM_TIMESTEPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 abort,
  input  logic [EC_SIZE-1:0]   spk_in,
  input  logic                 spk_in_valid,
  output logic                 spk_in_ready,
  output logic [ADDR_W-1:0]    spk_addr,
  output logic                 spk_addr_valid,
  output logic                 en_accum,
  output logic                 en_activ,
  input  logic [POST_SIZE-1:0] neuron_spk,
  output logic [POST_SIZE-1:0] spk_out,
  output logic                 spk_out_valid,
  input  logic                 spk_out_ready,
  output logic [TS_W-1:0]      timestep,
  output logic                 busy,
  output logic                 done
);

  localparam int               PH_W    = (NEURON_LAT > 1) ? $clog2(NEURON_LAT) : 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(NEURON_LAT - 1);
  localparam logic [TS_W-1:0]  TS_LAST = TS_W'(NUM_TIMESTEPS - 1);

  seq_state_e             state_q, state_d;
  logic [EC_SIZE-1:0]     mask_q, mask_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [ADDR_W-1:0]      spk_addr_q, spk_addr_d;
  logic [POST_SIZE-1:0]   spk_out_q, spk_out_d;
  logic                   spk_in_ready_q, spk_in_ready_d;
  logic                   spk_addr_valid_q, spk_addr_valid_d;
  logic                   en_accum_q, en_accum_d;
  logic                   en_activ_q, en_activ_d;
  logic                   spk_out_valid_q, spk_out_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [EC_SIZE-1:0]     enc_vec;
  logic [ADDR_W-1:0]      enc_idx;
  logic                   enc_any;

  // In LOAD the encoder looks straight at spk_in so the first address is
  // registered on the handshake edge; afterwards it walks the pending mask.
  assign enc_vec = (state_q == LOAD) ? spk_in : mask_q;

  spike_priority_enc #(
    .WIDTH (EC_SIZE)
  ) u_prio_enc (
    .vec (enc_vec),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Both handshakes are plain valid/ready: a transfer happens on the rising
  // edge where valid and ready are both high; the producer holds its data
  // stable while valid is high and ready is low.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    phase_d    = phase_q;
    ts_d       = ts_q;
    spk_addr_d = spk_addr_q;
    spk_out_d  = spk_out_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = LOAD;
          ts_d    = '0;
        end
      end
      LOAD: begin
        if (spk_in_valid && spk_in_ready_q) begin
          mask_d = enc_vec & (enc_vec - EC_SIZE'(1));
          if (enc_any) begin
            state_d    = ACCUM;
            spk_addr_d = enc_idx;
          end else begin
            state_d = DRAIN;
            phase_d = PH_LAST;
          end
        end
      end
      ACCUM: begin
        if (enc_any) begin
          spk_addr_d = enc_idx;
          mask_d     = enc_vec & (enc_vec - EC_SIZE'(1));
        end else begin
          state_d = DRAIN;
          phase_d = PH_LAST;
        end
      end
      DRAIN: begin
        if (phase_q == '0) begin
          state_d = ACTIV;
          phase_d = PH_LAST;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ACTIV: begin
        if (phase_q == '0) begin
          state_d   = OUTPUT;
          spk_out_d = neuron_spk;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      OUTPUT: begin
        if (spk_out_ready) begin
          if (ts_q == TS_LAST) begin
            state_d = DONE;
            ts_d    = '0;
          end else begin
            state_d = LOAD;
            ts_d    = ts_q + TS_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      mask_d     = '0;
      phase_d    = '0;
      ts_d       = '0;
      spk_addr_d = '0;
      spk_out_d  = '0;
    end

    // Control outputs are a registered decode of the next state.
    spk_in_ready_d   = (state_d == LOAD);
    spk_addr_valid_d = (state_d == ACCUM);
    en_accum_d       = (state_d == ACCUM);
    en_activ_d       = (state_d == ACTIV);
    spk_out_valid_d  = (state_d == OUTPUT);
    busy_d           = (state_d != IDLE);
    done_d           = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      mask_q           <= '0;
      phase_q          <= '0;
      ts_q             <= '0;
      spk_addr_q       <= '0;
      spk_out_q        <= '0;
      spk_in_ready_q   <= 1'b0;
      spk_addr_valid_q <= 1'b0;
      en_accum_q       <= 1'b0;
      en_activ_q       <= 1'b0;
      spk_out_valid_q  <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      mask_q           <= mask_d;
      phase_q          <= phase_d;
      ts_q             <= ts_d;
      spk_addr_q       <= spk_addr_d;
      spk_out_q        <= spk_out_d;
      spk_in_ready_q   <= spk_in_ready_d;
      spk_addr_valid_q <= spk_addr_valid_d;
      en_accum_q       <= en_accum_d;
      en_activ_q       <= en_activ_d;
      spk_out_valid_q  <= spk_out_valid_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign spk_in_ready   = spk_in_ready_q;
  assign spk_addr       = spk_addr_q;
  assign spk_addr_valid = spk_addr_valid_q;
  assign en_accum       = en_accum_q;
  assign en_activ       = en_activ_q;
  assign spk_out        = spk_out_q;
  assign spk_out_valid  = spk_out_valid_q;
  assign timestep       = ts_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_spike_event_sequencer.sv
// Bench for spike_event_sequencer: table-driven and random inferences checked
// against a timestep-level model, plus abort and async-reset sequences.
module tb_spike_event_sequencer;

  localparam int EC  = 8;
  localparam int PS  = 8;
  localparam int NL  = 4;
  localparam int NT  = 3;
  localparam int AW  = $clog2(EC);
  localparam int TW  = $clog2(NT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          abort;
  logic [EC-1:0] spk_in;
  logic          spk_in_valid;
  logic          spk_in_ready;
  logic [AW-1:0] spk_addr;
  logic          spk_addr_valid;
  logic          en_accum;
  logic          en_activ;
  logic [PS-1:0] neuron_spk;
  logic [PS-1:0] spk_out;
  logic          spk_out_valid;
  logic          spk_out_ready;
  logic [TW-1:0] timestep;
  logic          busy;
  logic          done;

  spike_event_sequencer #(
    .EC_SIZE       (EC),
    .POST_SIZE     (PS),
    .NEURON_LAT    (NL),
    .NUM_TIMESTEPS (NT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .abort          (abort),
    .spk_in         (spk_in),
    .spk_in_valid   (spk_in_valid),
    .spk_in_ready   (spk_in_ready),
    .spk_addr       (spk_addr),
    .spk_addr_valid (spk_addr_valid),
    .en_accum       (en_accum),
    .en_activ       (en_activ),
    .neuron_spk     (neuron_spk),
    .spk_out        (spk_out),
    .spk_out_valid  (spk_out_valid),
    .spk_out_ready  (spk_out_ready),
    .timestep       (timestep),
    .busy           (busy),
    .done           (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [EC-1:0] exp_q[$];

  typedef struct {
    logic [EC-1:0] spk;
    int            stall;
    int            exp_lat;
  } ts_vec_t;

  ts_vec_t dir_tab[NT];
  ts_vec_t run_tab[NT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: addresses are the set bits in ascending order; a timestep is
  // popcount accumulate cycles, NL drain, NL activate, then output.
  function automatic int popcount8(input logic [EC-1:0] v);
    int n = 0;
    for (int b = 0; b < EC; b++) if (v[b]) n++;
    return n;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_spk_in_ready"},   32'(spk_in_ready),   0);
    chk({tag, "_spk_addr"},       32'(spk_addr),       0);
    chk({tag, "_spk_addr_valid"}, 32'(spk_addr_valid), 0);
    chk({tag, "_en_accum"},       32'(en_accum),       0);
    chk({tag, "_en_activ"},       32'(en_activ),       0);
    chk({tag, "_spk_out"},        32'(spk_out),        0);
    chk({tag, "_spk_out_valid"},  32'(spk_out_valid),  0);
    chk({tag, "_timestep"},       32'(timestep),       0);
    chk({tag, "_busy"},           32'(busy),           0);
    chk({tag, "_done"},           32'(done),           0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_timestep(input ts_vec_t v, input int ts_idx, input bit last);
    logic [PS-1:0] out_exp;
    logic [EC-1:0] last_addr;
    int            k;
    int            pop;
    out_exp   = '0;
    last_addr = '0;
    chk("load_ready", 32'(spk_in_ready), 1);
    chk("load_ts",    32'(timestep),     32'(ts_idx));
    chk("load_busy",  32'(busy),         1);

    exp_q.delete();
    for (int b = 0; b < EC; b++) if (v.spk[b]) exp_q.push_back(EC'(b));
    pop = exp_q.size();

    spk_in       = v.spk;
    spk_in_valid = 1'b1;
    step();
    spk_in_valid = 1'b0;
    spk_in       = EC'($urandom);

    k = 1;
    while (!spk_out_valid && k <= 64) begin
      chk("no_overlap", 32'(en_accum & en_activ), 0);
      chk("ts_hold",    32'(timestep),            32'(ts_idx));
      chk("ready_low",  32'(spk_in_ready),        0);
      if (k <= pop) begin
        chk("accum_en",   32'(en_accum),       1);
        chk("addr_valid", 32'(spk_addr_valid), 1);
        if (exp_q.size() > 0) begin
          last_addr = exp_q.pop_front();
          chk("spk_addr", 32'(spk_addr), 32'(last_addr));
        end
      end else if (k <= pop + NL) begin
        chk("drain_accum", 32'(en_accum),       0);
        chk("drain_valid", 32'(spk_addr_valid), 0);
        chk("drain_activ", 32'(en_activ),       0);
        if (pop > 0) chk("addr_hold", 32'(spk_addr), 32'(last_addr));
      end else begin
        chk("activ_en",    32'(en_activ),       1);
        chk("activ_valid", 32'(spk_addr_valid), 0);
        neuron_spk = PS'($urandom);
        out_exp    = neuron_spk;
      end
      enable       = 1'($urandom);
      spk_in_valid = 1'($urandom);
      step();
      k++;
    end
    chk("latency",   32'(k),             32'(v.exp_lat));
    chk("out_valid", 32'(spk_out_valid), 1);
    chk("spk_out",   32'(spk_out),       32'(out_exp));

    for (int s = 0; s < v.stall; s++) begin
      neuron_spk = PS'($urandom);
      step();
      chk("stall_valid",  32'(spk_out_valid), 1);
      chk("stall_stable", 32'(spk_out),       32'(out_exp));
    end

    enable        = 1'b0;
    spk_in_valid  = 1'b0;
    spk_out_ready = 1'b1;
    step();
    spk_out_ready = 1'b0;
    if (last) begin
      chk("done_pulse",   32'(done),          1);
      chk("done_ts",      32'(timestep),      0);
      chk("done_out_kept", 32'(spk_out),      32'(out_exp));
      chk("done_valid",   32'(spk_out_valid), 0);
      step();
      chk("done_once",    32'(done),          0);
      chk("end_idle",     32'(busy),          0);
      chk("end_out_kept", 32'(spk_out),       32'(out_exp));
    end else begin
      chk("next_no_done", 32'(done), 0);
    end
  endtask

  task automatic run_inference();
    chk("start_idle", 32'(busy), 0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int t = 0; t < NT; t++) run_timestep(run_tab[t], t, (t == NT - 1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst           = 1'b0;
    enable        = 1'b0;
    abort         = 1'b0;
    spk_in        = '0;
    spk_in_valid  = 1'b0;
    neuron_spk    = '0;
    spk_out_ready = 1'b0;

    dir_tab[0] = '{spk: 8'b1010_0101, stall: 0, exp_lat: 13};
    dir_tab[1] = '{spk: 8'h00,        stall: 5, exp_lat: 9};
    dir_tab[2] = '{spk: 8'hFF,        stall: 0, exp_lat: 17};

    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    step();
    check_zero("post_reset");

    // spk_in_valid outside LOAD is ignored
    spk_in       = 8'hFF;
    spk_in_valid = 1'b1;
    step();
    chk("idle_ignore_ready", 32'(spk_in_ready), 0);
    chk("idle_ignore_busy",  32'(busy),         0);
    spk_in_valid = 1'b0;

    run_tab = dir_tab;
    run_inference();

    repeat (4) begin
      for (int t = 0; t < NT; t++) begin
        run_tab[t].spk     = EC'($urandom_range(0, 255));
        run_tab[t].stall   = $urandom_range(0, 3);
        run_tab[t].exp_lat = popcount8(run_tab[t].spk) + 2 * NL + 1;
      end
      run_inference();
    end

    // abort on the second accumulate cycle
    enable = 1'b1;
    step();
    enable       = 1'b0;
    spk_in       = 8'b1010_0101;
    spk_in_valid = 1'b1;
    step();
    spk_in_valid = 1'b0;
    chk("abort_addr0", 32'(spk_addr), 0);
    step();
    chk("abort_addr1", 32'(spk_addr), 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_zero("abort");
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_done", 32'(done), 0);
      chk("abort_idle",    32'(busy), 0);
    end
    run_tab = dir_tab;
    run_inference();

    // asynchronous reset in the middle of ACTIV
    enable = 1'b1;
    step();
    enable       = 1'b0;
    spk_in       = 8'h01;
    spk_in_valid = 1'b1;
    step();
    spk_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pre_rst_activ", 32'(en_activ), 1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step();
    check_zero("rst_release");
    run_tab = dir_tab;
    run_inference();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
